decoder_onehot_scan: RTL and testbench
======================================

Name: decoder_onehot_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable, successor to the team's combinational 2-to-4 enable decoder.
- Adds a second mode: an auto-scan sequencer that walks the one-hot output through all channels, with a programmable dwell time and a wrap pulse.
- Drives channel selects, such as LED/7-seg digit strobes or mux enables, in the lab designs.

Parameters:
- SEL_W, 2, select width; output width is 2**SEL_W (legal 1..6).
- DWELL, 4, cycles each channel stays active in scan mode (legal >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  output enable; low forces outputs idle
- mode  input  1  0 = direct decode, 1 = auto-scan
- y  input  SEL_W  select value (direct), start index (scan load)
- load  input  1  scan mode: restart scan at index y
- D  output  2**SEL_W  registered one-hot output
- idx  output  SEL_W  registered index currently decoded
- wrap  output  1  one-cycle pulse when scan index wraps max->0

Behaviour:
- Reset (rst_n=0 at posedge): D=0, idx=0, dwell counter=0, wrap=0, mode_q=0. Synchronous only; rst_n has priority over all inputs.
- Dwell counter width is max(1,$clog2(DWELL)). All outputs are registered and there is no combinational path from inputs to D.
- Direct mode (mode=1'b0):
  - Latency 1: D <= en ? (1<<y) : 0; idx <= y regardless of en.
  - wrap=0; dwell counter held at 0.
- Scan mode (mode=1'b1):
  - Entry: mode_q tracks mode. On the first scan cycle (mode=1, mode_q=0): idx <= y, cnt <= 0.
  - load=1 in scan mode: idx <= y, cnt <= 0, wrap=0. load beats a step in the same cycle. load is ignored in direct mode.
  - en=1, no load:
    - If cnt==DWELL-1: cnt <= 0, idx <= idx+1 mod 2**SEL_W, and wrap <= 1 iff idx was 2**SEL_W-1.
    - Otherwise cnt <= cnt+1, wrap <= 0.
  - en=0: idx and cnt frozen, D <= 0, wrap <= 0. On en returning high, the scan resumes from the frozen idx/cnt.
  - D <= en ? (1<<idx_next) : 0, so D always matches the registered idx in the same cycle.
- DWELL=1: the index advances every enabled cycle.
- Switching scan->direct: the next cycle behaves as direct mode and cnt clears to 0.
- Reset mid-scan: all state returns to the reset values and the scan restarts from idx=0 after the first scan-entry cycle.

Optional Feature:
- Macro DECODER_ACTIVE_LOW_EN.
- Defined:
  - D is active-low one-hot (single 0).
  - Idle/reset/en=0 value is all ones.
  - idx and wrap are unchanged.
- Undefined: active-high as described above; idle value all zeros.

Test Plan:
- Reset, SEL_W=2: hold rst_n=0 for 2 cycles with en=1, y=2'b11 -> D=4'b0000, idx=0, wrap=0; after release with mode=0, next edge D=4'b1000.
- Direct decode sweep, en=1, y=0..3 on consecutive cycles -> D=0001, 0010, 0100, 1000, each one cycle after its y; en=0 -> D=0000 next cycle, idx still tracks y.
- Scan, DWELL=4, enter with y=2 -> D=0100 for 4 cycles, 1000 for 4, then 0001 with wrap=1 for exactly one cycle on the 3->0 step, then 0010.
- Scan freeze: drop en for 3 cycles mid-dwell on idx=1 after 2 dwell cycles -> D=0000 and idx=1 held; after en=1, D=0010 for the remaining 2 cycles, then 0100.
- Load priority: assert load with y=0 on the same cycle idx=3 and cnt==DWELL-1 -> idx=0, D=0001, wrap=0, and a full 4-cycle dwell follows.
- Macro defined, SEL_W=3, DWELL=1: reset -> D=8'hFF; scan from y=7 -> D=8'h7F, then 8'hFE with wrap=1, then 8'hFD; en=0 -> 8'hFF.

Source files
------------

// File: rtl/decoder_onehot_scan.sv
// Registered N-to-2^N one-hot decoder with direct-decode and auto-scan modes.
// Optional macro DECODER_ACTIVE_LOW_EN makes D active-low (idle value all ones).
module decoder_onehot_scan #(
   parameter int SEL_W = 2,
   parameter int DWELL = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      y,
   input  logic                  load,
   output logic [2**SEL_W-1:0]   D,
   output logic [SEL_W-1:0]      idx,
   output logic                  wrap
);

   localparam int N     = 2**SEL_W;
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);

`ifdef DECODER_ACTIVE_LOW_EN
   localparam logic ACT_LOW = 1'b1;
`else
   localparam logic ACT_LOW = 1'b0;
`endif
   localparam logic [N-1:0] IDLE = {N{ACT_LOW}};

   logic [N-1:0]     d_q, d_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             mode_q;
   logic [N-1:0]     onehot;

   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (!mode) begin
         idx_d = y;
         cnt_d = '0;
      end else if (!mode_q || load) begin
         // scan entry and explicit load both restart at y and beat any step
         idx_d = y;
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            idx_d  = idx_q + SEL_W'(1);
            wrap_d = (idx_q == IDX_MAX);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      onehot        = '0;
      onehot[idx_d] = en;
      d_d           = ACT_LOW ? ~onehot : onehot;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_q    <= IDLE;
         idx_q  <= '0;
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         mode_q <= 1'b0;
      end else begin
         d_q    <= d_d;
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         mode_q <= mode;
      end
   end

   assign D    = d_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_onehot_scan.sv
// Directed bench: table-driven vectors on a SEL_W=2/DWELL=4 instance plus a
// hand sequence on a SEL_W=3/DWELL=1 instance; expected D given active-high.
module tb_decoder_onehot_scan;

`ifdef DECODER_ACTIVE_LOW_EN
   localparam bit AL = 1'b1;
`else
   localparam bit AL = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A
   logic       rst_a_n, en_a, mode_a, load_a;
   logic [1:0] y_a;
   logic [3:0] d_a;
   logic [1:0] idx_a;
   logic       wrap_a;
   // instance B
   logic       rst_b_n, en_b, mode_b, load_b;
   logic [2:0] y_b;
   logic [7:0] d_b;
   logic [2:0] idx_b;
   logic       wrap_b;

   decoder_onehot_scan #(.SEL_W(2), .DWELL(4)) u_a (
      .clk(clk), .rst_n(rst_a_n), .en(en_a), .mode(mode_a), .y(y_a),
      .load(load_a), .D(d_a), .idx(idx_a), .wrap(wrap_a));

   decoder_onehot_scan #(.SEL_W(3), .DWELL(1)) u_b (
      .clk(clk), .rst_n(rst_b_n), .en(en_b), .mode(mode_b), .y(y_b),
      .load(load_b), .D(d_b), .idx(idx_b), .wrap(wrap_b));

   typedef struct {
      logic       rst_n, en, mode, load;
      logic [1:0] y;
      logic [3:0] d;
      logic [1:0] idx;
      logic       wrap;
   } vec_t;

   vec_t tv[$];
   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(input logic r, input logic e, input logic m,
                               input logic l, input logic [1:0] yy,
                               input logic [3:0] d, input logic [1:0] ix,
                               input logic w);
      vec_t v;
      v.rst_n = r; v.en = e; v.mode = m; v.load = l; v.y = yy;
      v.d = d; v.idx = ix; v.wrap = w;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h, expected %h", name, row, got, exp);
      end
   endtask

   function automatic logic [3:0] pa(input logic [3:0] v);
      return AL ? ~v : v;
   endfunction
   function automatic logic [7:0] pb(input logic [7:0] v);
      return AL ? ~v : v;
   endfunction

   task automatic step_b(input logic r, input logic e, input logic m,
                         input logic l, input logic [2:0] yy,
                         input logic [7:0] d, input logic [2:0] ix,
                         input logic w, input int row);
      rst_b_n = r; en_b = e; mode_b = m; load_b = l; y_b = yy;
      @(posedge clk); #1;
      chk("B.D", row, d_b, pb(d));
      chk("B.idx", row, {5'd0, idx_b}, {5'd0, ix});
      chk("B.wrap", row, {7'd0, wrap_b}, {7'd0, w});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // reset with en=1, y=3
      tv.push_back(mk(0,1,0,0,3, 4'b0000,0,0));
      tv.push_back(mk(0,1,0,0,3, 4'b0000,0,0));
      tv.push_back(mk(1,1,0,0,3, 4'b1000,3,0));
      // direct sweep, then en=0 with idx tracking y
      tv.push_back(mk(1,1,0,0,0, 4'b0001,0,0));
      tv.push_back(mk(1,1,0,0,1, 4'b0010,1,0));
      tv.push_back(mk(1,1,0,0,2, 4'b0100,2,0));
      tv.push_back(mk(1,1,0,0,3, 4'b1000,3,0));
      tv.push_back(mk(1,0,0,0,1, 4'b0000,1,0));
      tv.push_back(mk(1,0,0,1,2, 4'b0000,2,0));
      // scan entry at y=2, y ignored afterwards
      tv.push_back(mk(1,1,1,0,2, 4'b0100,2,0));
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,1,0,0, 4'b0100,2,0));
      for (int i = 0; i < 4; i++) tv.push_back(mk(1,1,1,0,0, 4'b1000,3,0));
      tv.push_back(mk(1,1,1,0,0, 4'b0001,0,1));
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,1,0,0, 4'b0001,0,0));
      tv.push_back(mk(1,1,1,0,0, 4'b0010,1,0));
      tv.push_back(mk(1,1,1,0,0, 4'b0010,1,0));
      // freeze 3 cycles after 2 dwell cycles on idx=1
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,1,0,3, 4'b0000,1,0));
      tv.push_back(mk(1,1,1,0,0, 4'b0010,1,0));
      tv.push_back(mk(1,1,1,0,0, 4'b0010,1,0));
      tv.push_back(mk(1,1,1,0,0, 4'b0100,2,0));
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,1,0,0, 4'b0100,2,0));
      for (int i = 0; i < 4; i++) tv.push_back(mk(1,1,1,0,0, 4'b1000,3,0));
      // load at idx=3, cnt=DWELL-1 beats the wrapping step
      tv.push_back(mk(1,1,1,1,0, 4'b0001,0,0));
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,1,0,2, 4'b0001,0,0));
      tv.push_back(mk(1,1,1,0,2, 4'b0010,1,0));
      tv.push_back(mk(1,1,1,0,2, 4'b0010,1,0));
      // scan -> direct mid-dwell, then re-enter
      tv.push_back(mk(1,1,0,1,3, 4'b1000,3,0));
      tv.push_back(mk(1,1,1,0,1, 4'b0010,1,0));
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,1,0,3, 4'b0010,1,0));
      tv.push_back(mk(1,1,1,0,3, 4'b0100,2,0));
      // reset mid-scan, restart from 0
      tv.push_back(mk(0,1,1,0,3, 4'b0000,0,0));
      tv.push_back(mk(1,1,1,0,0, 4'b0001,0,0));
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,1,0,3, 4'b0001,0,0));
      tv.push_back(mk(1,1,1,0,3, 4'b0010,1,0));

      rst_a_n = 1'b0; en_a = 1'b0; mode_a = 1'b0; load_a = 1'b0; y_a = '0;
      rst_b_n = 1'b0; en_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; y_b = '0;
      @(posedge clk); #1;

      foreach (tv[i]) begin
         rst_a_n = tv[i].rst_n; en_a = tv[i].en; mode_a = tv[i].mode;
         load_a = tv[i].load; y_a = tv[i].y;
         @(posedge clk); #1;
         chk("A.D", i, {4'd0, d_a}, {4'd0, pa(tv[i].d)});
         chk("A.idx", i, {6'd0, idx_a}, {6'd0, tv[i].idx});
         chk("A.wrap", i, {7'd0, wrap_a}, {7'd0, tv[i].wrap});
      end

      // SEL_W=3, DWELL=1: advances every enabled cycle
      step_b(0,1,1,0,3'd5, 8'h00,3'd0,0, 100);
      step_b(1,1,1,0,3'd7, 8'h80,3'd7,0, 101);
      step_b(1,1,1,0,3'd2, 8'h01,3'd0,1, 102);
      step_b(1,1,1,0,3'd2, 8'h02,3'd1,0, 103);
      step_b(1,0,1,0,3'd2, 8'h00,3'd1,0, 104);
      step_b(1,1,1,0,3'd2, 8'h04,3'd2,0, 105);
      step_b(1,1,1,1,3'd6, 8'h40,3'd6,0, 106);
      step_b(1,1,1,0,3'd0, 8'h80,3'd7,0, 107);
      step_b(1,1,1,0,3'd0, 8'h01,3'd0,1, 108);
      step_b(1,1,0,0,3'd4, 8'h10,3'd4,0, 109);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
